// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage for the multicycle controller.
// Owns the unified instruction/data word memory, the IR and the MDR.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   mem_req                 start an access (sampled only when idle)
//   IorD                    address select: 0 = pc, 1 = alu_out
//   MemWrite, IRWrite       store enable, IR load on read
//   pc, alu_out, wdata      byte addresses and store data
//   instr, mdr              IR and MDR contents
//   op, funct               combinational fields of instr
//   busy, done, err         access in progress, completion pulse, misaligned
module mem_access_unit #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LAT    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_req,
   input  logic        IorD,
   input  logic        MemWrite,
   input  logic        IRWrite,
   input  logic [31:0] pc,
   input  logic [31:0] alu_out,
   input  logic [31:0] wdata,
   output logic [31:0] instr,
   output logic [31:0] mdr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned BA_W  = ADDR_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t            r_state;
   logic [BA_W-1:0]   r_addr;
   logic              r_we;
   logic              r_ir_en;
   logic [31:0]       r_wd;
   logic [CNT_W-1:0]  r_cnt;
   logic [31:0]       r_instr;
   logic [31:0]       r_mdr;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [31:0]       r_mem [DEPTH];

   logic [ADDR_W-1:0] w_idx;
   logic              w_misal;
   logic              w_commit;
   logic              w_unused;

   assign w_idx    = r_addr[BA_W-1:2];
   assign w_misal  = (r_addr[1:0] != 2'b00);
   assign w_commit = (r_state == S_WAIT) && !w_misal && (r_cnt == '0);
   // Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
   assign w_unused = ^{pc[31:BA_W], alu_out[31:BA_W]};

   // Memory array: not reset; a reset forces IDLE so no write can commit.
   always_ff @(posedge clk) begin
      if (w_commit && r_we) r_mem[w_idx] <= r_wd;
   end

   // Access sequencer with registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_ir_en <= 1'b0;
         r_wd    <= '0;
         r_cnt   <= '0;
         r_instr <= '0;
         r_mdr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mem_req) begin
                  r_addr  <= IorD ? alu_out[BA_W-1:0] : pc[BA_W-1:0];
                  r_we    <= MemWrite;
                  r_ir_en <= IRWrite & ~MemWrite;
                  r_wd    <= wdata;
                  r_cnt   <= CNT_W'(LAT - 1);
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_misal) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  if (!r_we) begin
                     r_mdr <= r_mem[w_idx];
                     if (r_ir_en) r_instr <= r_mem[w_idx];
                  end
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign instr = r_instr;
   assign mdr   = r_mdr;
   assign op    = r_instr[31:26];
   assign funct = r_instr[5:0];
   assign busy  = r_busy;
   assign done  = r_done;
   assign err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (DEPTH=256, LAT=2).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic        IorD;
   logic        MemWrite;
   logic        IRWrite;
   logic [31:0] pc;
   logic [31:0] alu_out;
   logic [31:0] wdata;
   logic [31:0] instr;
   logic [31:0] mdr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        busy;
   logic        done;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   mem_access_unit #(.DEPTH(256), .ADDR_W(8), .LAT(2)) dut (
      .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .IorD(IorD),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .pc(pc), .alu_out(alu_out),
      .wdata(wdata), .instr(instr), .mdr(mdr), .op(op), .funct(funct),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access: checks latency, err, busy and the trailing done drop.
   task automatic do_access(input string tag, input logic iord, input logic mw,
                            input logic irw, input logic [31:0] pcv,
                            input logic [31:0] aluv, input logic [31:0] wd,
                            input int lat, input logic exp_err);
      int n;
      @(negedge clk);
      mem_req = 1'b1; IorD = iord; MemWrite = mw; IRWrite = irw;
      pc = pcv; alu_out = aluv; wdata = wd;
      @(posedge clk); #1;
      mem_req = 1'b0;
      IorD = 1'($urandom); MemWrite = 1'($urandom); IRWrite = 1'($urandom);
      pc = $urandom; alu_out = $urandom; wdata = $urandom;
      chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(lat));
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_done_drop"}, 32'({busy, done, err}), 32'd0);
   endtask

   initial begin
      int dones;
      rst_n = 1'b0; mem_req = 1'b0; IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
      pc = '0; alu_out = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_instr", instr, 32'd0);
      chk("rst_mdr", mdr, 32'd0);
      chk("rst_status", 32'({busy, done, err}), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // 1: preload mem[1] then fetch from pc=4
      do_access("pre1", 1'b1, 1'b1, 1'b0, 32'h0, 32'h4, 32'h8C220004, 2, 1'b0);
      chk("pre1_mdr", mdr, 32'd0);
      do_access("fetch", 1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 2, 1'b0);
      chk("fetch_instr", instr, 32'h8C220004);
      chk("fetch_op", 32'(op), 32'h23);
      chk("fetch_funct", 32'(funct), 32'h04);
      chk("fetch_mdr", mdr, 32'h8C220004);

      // 2: store then load-back through alu_out
      do_access("st10", 1'b1, 1'b1, 1'b0, 32'h0, 32'h10, 32'hDEADBEEF, 2, 1'b0);
      chk("st10_mem4", dut.r_mem[4], 32'hDEADBEEF);
      do_access("ld10", 1'b1, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0, 2, 1'b0);
      chk("ld10_mdr", mdr, 32'hDEADBEEF);
      chk("ld10_instr", instr, 32'h8C220004);

      // 3: misaligned read
      do_access("mis", 1'b1, 1'b0, 1'b1, 32'h0, 32'h402, 32'h0, 1, 1'b1);
      chk("mis_mdr", mdr, 32'hDEADBEEF);
      chk("mis_instr", instr, 32'h8C220004);

      // 4: wrapping store (IRWrite ignored on a store), then read via pc
      do_access("wrap_st", 1'b1, 1'b1, 1'b1, 32'h0, 32'h400, 32'h5, 2, 1'b0);
      chk("wrap_mem0", dut.r_mem[0], 32'h5);
      chk("wrap_st_instr", instr, 32'h8C220004);
      chk("wrap_st_mdr", mdr, 32'hDEADBEEF);
      do_access("wrap_ld", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 2, 1'b0);
      chk("wrap_ld_mdr", mdr, 32'h5);

      // 5: mem_req held through WAIT and DONE is ignored
      @(negedge clk);
      mem_req = 1'b1; IorD = 1'b1; MemWrite = 1'b0; IRWrite = 1'b0; alu_out = 32'h10;
      @(posedge clk); #1;
      dones = 0;
      repeat (3) begin
         chk("hold_busy", 32'(busy), 32'd1);
         @(posedge clk); #1;
         if (done) dones++;
      end
      mem_req = 1'b0;
      chk("hold_single_done", 32'(dones), 32'd1);
      chk("hold_idle", 32'({busy, done}), 32'd0);
      @(posedge clk); #1;
      chk("hold_not_queued", 32'(busy), 32'd0);
      chk("hold_mdr", mdr, 32'hDEADBEEF);
      do_access("after_hold", 1'b0, 1'b0, 1'b1, 32'h4, 32'h0, 32'h0, 2, 1'b0);
      chk("after_hold_mdr", mdr, 32'h8C220004);

      // 6: reset one cycle into a store aborts it
      do_access("clr2", 1'b1, 1'b1, 1'b0, 32'h0, 32'h8, 32'h0, 2, 1'b0);
      @(negedge clk);
      mem_req = 1'b1; IorD = 1'b1; MemWrite = 1'b1; IRWrite = 1'b0;
      alu_out = 32'h8; wdata = 32'h12345678;
      @(posedge clk); #1;
      mem_req = 1'b0;
      @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      chk("abort_status", 32'({busy, done, err}), 32'd0);
      chk("abort_instr", instr, 32'd0);
      chk("abort_mdr", mdr, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_mem2", dut.r_mem[2], 32'd0);
      chk("abort_idle", 32'({busy, done, err}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
